// File: rtl/password_lock_param_if.sv
// password_lock_param_if: switch/strobe inputs and status/display outputs of the digit lock
// Optional macro: PASSWORD_PROGRAM_EN adds the prog input.
// Ports (master = board side, slave = lock):
//   digit_in  [DIGIT_W]                 digit value from switches
//   enter, clear                        level strobes, edge detected inside the lock
//   prog                                request code programming (PASSWORD_PROGRAM_EN only)
//   unlocked, lockout                   status LEDs
//   fail_cnt  [clog2(MAX_TRIES+1)]      consecutive failures
//   digit_idx [clog2(DIGITS+1)]         digits entered so far
//   seg_out   [7*DIGITS]                active-low segments, digit k at [7k+6:7k], bit 7k = a
interface password_lock_param_if #(
  parameter int DIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter int MAX_TRIES = 3
);
  logic [DIGIT_W-1:0] digit_in;
  logic enter;
  logic clear;
`ifdef PASSWORD_PROGRAM_EN
  logic prog;
`endif
  logic unlocked;
  logic lockout;
  logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt;
  logic [$clog2(DIGITS+1)-1:0] digit_idx;
  logic [7*DIGITS-1:0] seg_out;
`ifdef PASSWORD_PROGRAM_EN
  modport master(output digit_in, enter, clear, prog, input unlocked, lockout, fail_cnt, digit_idx, seg_out);
  modport slave(input digit_in, enter, clear, prog, output unlocked, lockout, fail_cnt, digit_idx, seg_out);
`else
  modport master(output digit_in, enter, clear, input unlocked, lockout, fail_cnt, digit_idx, seg_out);
  modport slave(input digit_in, enter, clear, output unlocked, lockout, fail_cnt, digit_idx, seg_out);
`endif
endinterface

// File: rtl/password_lock_param.sv
// password_lock_param: parametrised digit-sequence lock with seven-segment display, failure count and timed lockout
// Optional macro: PASSWORD_PROGRAM_EN adds a PROGRAM state that reloads the password from OPEN.
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-high
//   bus  password_lock_param_if.slave (digit_in, enter, clear, [prog] in; unlocked, lockout, fail_cnt, digit_idx, seg_out out)
module password_lock_param #(
  parameter int DIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] PASSWORD = 16'h1234,
  parameter int MAX_TRIES = 3,
  parameter int FAIL_CYCLES = 25_000_000,
  parameter int LOCK_CYCLES = 250_000_000
) (
  input logic clk,
  input logic rst,
  password_lock_param_if.slave bus
);
  localparam int CW = DIGITS * DIGIT_W;
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int XW = $clog2(DIGITS + 1);
  localparam int TMAX = FAIL_CYCLES > LOCK_CYCLES ? FAIL_CYCLES : LOCK_CYCLES;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef enum logic [2:0] {
    ENTRY, CHECK, OPEN, FAIL, LOCKOUT
`ifdef PASSWORD_PROGRAM_EN
    , PROGRAM
`endif
  } state_t;
  state_t r_state, w_state;
  logic [CW-1:0] r_buf, w_buf, w_buf_wr, w_pw;
  logic [XW-1:0] r_idx, w_idx;
  logic [FW-1:0] r_fail, w_fail, w_fail_inc;
  logic [TW-1:0] r_timer, w_timer;
  logic r_enter, r_clear, w_ent, w_clr;
  logic [7*DIGITS-1:0] w_seg;
`ifdef PASSWORD_PROGRAM_EN
  logic [CW-1:0] r_pw, w_pw_nxt;
  assign w_pw = r_pw;
`else
  assign w_pw = PASSWORD;
`endif
  // clear has priority: a simultaneous enter edge is dropped
  assign w_clr = bus.clear & ~r_clear;
  assign w_ent = bus.enter & ~r_enter & ~w_clr;
  assign w_fail_inc = r_fail + FW'(1);
  // digit 0 lives in the most significant slot of the buffer
  always_comb begin
    w_buf_wr = r_buf;
    for (int k = 0; k < DIGITS; k++)
      if (r_idx == XW'(k)) w_buf_wr[CW-1-DIGIT_W*k -: DIGIT_W] = bus.digit_in;
  end
  always_comb begin
    w_state = r_state;
    w_buf = r_buf;
    w_idx = r_idx;
    w_fail = r_fail;
    w_timer = r_timer;
`ifdef PASSWORD_PROGRAM_EN
    w_pw_nxt = r_pw;
`endif
    case (r_state)
      ENTRY:
        if (r_idx == XW'(DIGITS)) w_state = CHECK;
        else if (w_clr) begin
          w_buf = '0;
          w_idx = '0;
        end else if (w_ent) begin
          w_buf = w_buf_wr;
          w_idx = r_idx + XW'(1);
        end
      CHECK: begin
        w_buf = '0;
        w_idx = '0;
        if (r_buf == w_pw) begin
          w_state = OPEN;
          w_fail = '0;
        end else if (w_fail_inc < FW'(MAX_TRIES)) begin
          w_state = FAIL;
          w_fail = w_fail_inc;
          w_timer = TW'(FAIL_CYCLES - 1);
        end else begin
          w_state = LOCKOUT;
          w_fail = FW'(MAX_TRIES);
          w_timer = TW'(LOCK_CYCLES - 1);
        end
      end
      FAIL: begin
        w_state = r_timer == '0 ? ENTRY : FAIL;
        w_timer = r_timer == '0 ? '0 : r_timer - TW'(1);
      end
      LOCKOUT: begin
        w_state = r_timer == '0 ? ENTRY : LOCKOUT;
        w_timer = r_timer == '0 ? '0 : r_timer - TW'(1);
        w_fail = r_timer == '0 ? '0 : r_fail;
      end
      OPEN:
        if (w_clr) w_state = ENTRY;
`ifdef PASSWORD_PROGRAM_EN
        else if (w_ent && bus.prog) begin
          w_state = PROGRAM;
          w_buf = '0;
          w_idx = '0;
        end
      PROGRAM:
        if (w_clr) begin
          w_state = ENTRY;
          w_buf = '0;
          w_idx = '0;
        end else if (w_ent && r_idx == XW'(DIGITS - 1)) begin
          w_pw_nxt = w_buf_wr;
          w_state = ENTRY;
          w_buf = '0;
          w_idx = '0;
        end else if (w_ent) begin
          w_buf = w_buf_wr;
          w_idx = r_idx + XW'(1);
        end
`endif
      default: w_state = ENTRY;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ENTRY;
      r_buf <= '0;
      r_idx <= '0;
      r_fail <= '0;
      r_timer <= '0;
      r_enter <= 1'b0;
      r_clear <= 1'b0;
`ifdef PASSWORD_PROGRAM_EN
      r_pw <= PASSWORD;
`endif
    end else begin
      r_state <= w_state;
      r_buf <= w_buf;
      r_idx <= w_idx;
      r_fail <= w_fail;
      r_timer <= w_timer;
      r_enter <= bus.enter;
      r_clear <= bus.clear;
`ifdef PASSWORD_PROGRAM_EN
      r_pw <= w_pw_nxt;
`endif
    end
  // entry-style states (ENTRY, CHECK, PROGRAM) show typed digits, dashes beyond idx
  always_comb begin
    w_seg = '0;
    for (int k = 0; k < DIGITS; k++)
      w_seg[7*k +: 7] = r_state == OPEN ? 7'h40 :
                        r_state == FAIL ? 7'h06 :
                        r_state == LOCKOUT ? (k == 0 ? 7'h47 : 7'h7F) :
                        XW'(k) < r_idx ? HEX[4'(r_buf[CW-1-DIGIT_W*k -: DIGIT_W])] : 7'h3F;
  end
  assign bus.seg_out = w_seg;
`ifdef PASSWORD_PROGRAM_EN
  assign bus.unlocked = r_state == OPEN || r_state == PROGRAM;
`else
  assign bus.unlocked = r_state == OPEN;
`endif
  assign bus.lockout = r_state == LOCKOUT;
  assign bus.fail_cnt = r_fail;
  assign bus.digit_idx = r_idx;
endmodule
